// File: rtl/xif_result_tracker.sv
// xif_result_tracker: in-order tracker of in-flight XIF coprocessor instructions.
// Entries are allocated at issue, marked by commit and done transactions, and
// retired from the head either as a result to the core or silently when killed.
// Optional feature macro: XIF_TRACKER_FLUSH_EN adds a flush input that kills
// every live entry not yet committed.
module xif_result_tracker #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32
) (
    input  logic                   ck,
    input  logic                   rst,
`ifdef XIF_TRACKER_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [X_ID_WIDTH-1:0]  alloc_id,
    input  logic [4:0]             alloc_rd,
    input  logic                   alloc_we,
    input  logic                   commit_valid,
    input  logic [X_ID_WIDTH-1:0]  commit_id,
    input  logic                   commit_kill,
    input  logic                   done_valid,
    input  logic [X_ID_WIDTH-1:0]  done_id,
    input  logic [FLEN-1:0]        done_data,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [X_ID_WIDTH-1:0]  result_id,
    output logic [4:0]             result_rd,
    output logic                   result_we,
    output logic [FLEN-1:0]        result_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Control state (reset) and per-entry payload (never reset).
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      vld_q, vld_d, cmt_q, cmt_d, kill_q, kill_d, done_q, done_d;
    logic [X_ID_WIDTH-1:0] id_q   [DEPTH];
    logic [X_ID_WIDTH-1:0] id_d   [DEPTH];
    logic [4:0]            rd_q   [DEPTH];
    logic [4:0]            rd_d   [DEPTH];
    logic                  we_q   [DEPTH];
    logic                  we_d   [DEPTH];
    logic [FLEN-1:0]       data_q [DEPTH];
    logic [FLEN-1:0]       data_d [DEPTH];

    logic                  alloc_fire, retire_fire, head_killed;
    logic [DEPTH-1:0]      cmt_hit, done_hit;
    logic                  cmt_found, done_found;
    logic [PTR_W-1:0]      idx;

    // No bypass: a full tracker stays unready even while the head retires.
    assign alloc_ready = (count_q < CNT_W'(DEPTH)) && !rst;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign count       = count_q;

    assign head_killed  = vld_q[head_q] && kill_q[head_q];
    assign result_valid = vld_q[head_q] && cmt_q[head_q] && done_q[head_q] && !kill_q[head_q];
    assign retire_fire  = head_killed || (result_valid && result_ready);

    assign result_id   = result_valid ? id_q[head_q]   : '0;
    assign result_rd   = result_valid ? rd_q[head_q]   : '0;
    assign result_we   = result_valid ? we_q[head_q]   : 1'b0;
    assign result_data = result_valid ? data_q[head_q] : '0;

    // Walk entries oldest-first from head to find the commit and done targets;
    // the slot being allocated this cycle is visible to commit only.
    always_comb begin
        cmt_hit    = '0;
        done_hit   = '0;
        cmt_found  = 1'b0;
        done_found = 1'b0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (commit_valid && !cmt_found) begin
                if ((vld_q[idx] && (id_q[idx] == commit_id)) ||
                    (alloc_fire && (idx == tail_q) && (alloc_id == commit_id))) begin
                    cmt_hit[idx] = 1'b1;
                    cmt_found    = 1'b1;
                end
            end
            if (done_valid && !done_found) begin
                if (vld_q[idx] && !done_q[idx] && (id_q[idx] == done_id)) begin
                    done_hit[idx] = 1'b1;
                    done_found    = 1'b1;
                end
            end
        end
    end

    // Per-entry next state: allocate, then apply commit/done/flush, then retire.
    always_comb begin
        vld_d  = vld_q;
        cmt_d  = cmt_q;
        kill_d = kill_q;
        done_d = done_q;
        for (int i = 0; i < DEPTH; i++) begin
            id_d[i]   = id_q[i];
            rd_d[i]   = rd_q[i];
            we_d[i]   = we_q[i];
            data_d[i] = data_q[i];
            if (alloc_fire && (tail_q == PTR_W'(i))) begin
                vld_d[i]  = 1'b1;
                id_d[i]   = alloc_id;
                rd_d[i]   = alloc_rd;
                we_d[i]   = alloc_we;
                cmt_d[i]  = 1'b0;
                kill_d[i] = 1'b0;
                done_d[i] = 1'b0;
            end
            if (cmt_hit[i]) begin
                cmt_d[i] = 1'b1;
                if (commit_kill) begin
                    kill_d[i] = 1'b1;
                end
            end
            if (done_hit[i]) begin
                done_d[i] = 1'b1;
                data_d[i] = done_data;
            end
`ifdef XIF_TRACKER_FLUSH_EN
            // Using cmt_d lets a same-cycle non-kill commit shield its entry.
            if (flush && vld_d[i] && !cmt_d[i]) begin
                kill_d[i] = 1'b1;
            end
`endif
            if (retire_fire && (head_q == PTR_W'(i))) begin
                vld_d[i] = 1'b0;
            end
        end
    end

    // Pointer and occupancy bookkeeping; head and tail wrap independently.
    always_comb begin
        head_d  = retire_fire ? head_q + PTR_W'(1) : head_q;
        tail_d  = alloc_fire  ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (alloc_fire && !retire_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!alloc_fire && retire_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control registers; reset wins over every concurrent transaction.
    always_ff @(posedge ck) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            cmt_q   <= '0;
            kill_q  <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            cmt_q   <= cmt_d;
            kill_q  <= kill_d;
            done_q  <= done_d;
        end
    end

    // Payload registers; only meaningful while the matching valid bit is set.
    always_ff @(posedge ck) begin
        for (int i = 0; i < DEPTH; i++) begin
            id_q[i]   <= id_d[i];
            rd_q[i]   <= rd_d[i];
            we_q[i]   <= we_d[i];
            data_q[i] <= data_d[i];
        end
    end

endmodule

// File: tb/tb_xif_result_tracker.sv
// Directed testbench for xif_result_tracker (DEPTH=4, X_ID_WIDTH=4, FLEN=32).
// Flush scenario is built only when XIF_TRACKER_FLUSH_EN is defined.
module tb_xif_result_tracker;

    logic        ck = 1'b0;
    logic        rst;
`ifdef XIF_TRACKER_FLUSH_EN
    logic        flush;
`endif
    logic        alloc_valid, alloc_ready, alloc_we;
    logic [3:0]  alloc_id;
    logic [4:0]  alloc_rd;
    logic        commit_valid, commit_kill;
    logic [3:0]  commit_id;
    logic        done_valid;
    logic [3:0]  done_id;
    logic [31:0] done_data;
    logic        result_valid, result_ready, result_we;
    logic [3:0]  result_id;
    logic [4:0]  result_rd;
    logic [31:0] result_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 ck = ~ck;

    xif_result_tracker #(.DEPTH(4), .X_ID_WIDTH(4), .FLEN(32)) dut (
        .ck(ck), .rst(rst),
`ifdef XIF_TRACKER_FLUSH_EN
        .flush(flush),
`endif
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .alloc_rd(alloc_rd), .alloc_we(alloc_we),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .done_valid(done_valid), .done_id(done_id), .done_data(done_data),
        .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
        .result_rd(result_rd), .result_we(result_we), .result_data(result_data),
        .count(count)
    );

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_id = 0; alloc_rd = 0; alloc_we = 0;
        commit_valid = 0; commit_id = 0; commit_kill = 0;
        done_valid = 0; done_id = 0; done_data = 0; result_ready = 0;
`ifdef XIF_TRACKER_FLUSH_EN
        flush = 0;
`endif
    endtask

    task automatic test_reset();
        idle(); rst = 1; step(); step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b want 0", result_valid); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got %b want 0", alloc_ready); end
        checks++; if ({result_id, result_rd, result_we, result_data} !== 42'd0) begin errors++; $display("FAIL reset_fields got %h want 0", {result_id, result_rd, result_we, result_data}); end
        rst = 0; #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", alloc_ready); end
    endtask

    task automatic test_basic();
        alloc_valid = 1; alloc_id = 3; alloc_rd = 7; alloc_we = 1; step(); idle();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1 got %0d want 1", count); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_rv_early got %b want 0", result_valid); end
        commit_valid = 1; commit_id = 3; done_valid = 1; done_id = 3; done_data = 32'h3F800000; step(); idle();
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_rv got %b want 1", result_valid); end
        checks++; if (result_id !== 4'd3) begin errors++; $display("FAIL basic_id got %0d want 3", result_id); end
        checks++; if (result_rd !== 5'd7 || result_we !== 1'b1) begin errors++; $display("FAIL basic_rd_we got %0d/%b want 7/1", result_rd, result_we); end
        checks++; if (result_data !== 32'h3F800000) begin errors++; $display("FAIL basic_data got %h want 3f800000", result_data); end
        result_ready = 1; step(); idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count0 got %0d want 0", count); end
        checks++; if (result_valid !== 1'b0 || result_data !== 32'd0) begin errors++; $display("FAIL basic_retired got %b/%h want 0/0", result_valid, result_data); end
        // Commit in the same cycle as the allocation, stray done ignored.
        alloc_valid = 1; alloc_id = 6; alloc_rd = 2; alloc_we = 1; commit_valid = 1; commit_id = 6; step(); idle();
        done_valid = 1; done_id = 9; done_data = 32'h1; step(); idle();
        checks++; if (result_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL stray_done got %b/%0d want 0/1", result_valid, count); end
        done_valid = 1; done_id = 6; done_data = 32'hDEADBEEF; step(); idle();
        checks++; if (result_valid !== 1'b1 || result_id !== 4'd6 || result_data !== 32'hDEADBEEF) begin errors++; $display("FAIL same_cycle_commit got %b/%0d/%h want 1/6/deadbeef", result_valid, result_id, result_data); end
        result_ready = 1; step(); idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL same_cycle_count got %0d want 0", count); end
    endtask

    task automatic test_in_order();
        alloc_valid = 1; alloc_id = 1; alloc_rd = 1; alloc_we = 1; step(); idle();
        alloc_valid = 1; alloc_id = 2; alloc_rd = 2; alloc_we = 1; step(); idle();
        done_valid = 1; done_id = 2; done_data = 32'h22; step(); idle();
        done_valid = 1; done_id = 1; done_data = 32'h11; step(); idle();
        commit_valid = 1; commit_id = 2; step(); idle();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL order_young_first got %b want 0", result_valid); end
        commit_valid = 1; commit_id = 1; step(); idle();
        checks++; if (result_valid !== 1'b1 || result_id !== 4'd1 || result_data !== 32'h11) begin errors++; $display("FAIL order_first got %b/%0d/%h want 1/1/11", result_valid, result_id, result_data); end
        result_ready = 1; step(); idle();
        checks++; if (result_valid !== 1'b1 || result_id !== 4'd2 || result_data !== 32'h22) begin errors++; $display("FAIL order_second got %b/%0d/%h want 1/2/22", result_valid, result_id, result_data); end
        result_ready = 1; step(); idle();
        checks++; if (count !== 3'd0 || result_valid !== 1'b0) begin errors++; $display("FAIL order_drain got %0d/%b want 0/0", count, result_valid); end
    endtask

    task automatic test_hold();
        alloc_valid = 1; alloc_id = 9; alloc_rd = 3; alloc_we = 0; step(); idle();
        commit_valid = 1; commit_id = 9; done_valid = 1; done_id = 9; done_data = 32'h12345678; step(); idle();
        for (int c = 0; c < 3; c++) begin
            checks++; if (result_valid !== 1'b1 || result_id !== 4'd9 || result_rd !== 5'd3 || result_we !== 1'b0 || result_data !== 32'h12345678) begin
                errors++; $display("FAIL hold_cycle%0d got %b/%0d/%0d/%b/%h want 1/9/3/0/12345678", c, result_valid, result_id, result_rd, result_we, result_data);
            end
            step();
        end
        result_ready = 1; step(); idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL hold_retire got %0d want 0", count); end
    endtask

    task automatic test_kill();
        alloc_valid = 1; alloc_id = 5; alloc_rd = 5; alloc_we = 1; step(); idle();
        commit_valid = 1; commit_id = 5; commit_kill = 1; step(); idle();
        checks++; if (result_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL kill_marked got %b/%0d want 0/1", result_valid, count); end
        step();
        checks++; if (result_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL kill_retired got %b/%0d want 0/0", result_valid, count); end
        done_valid = 1; done_id = 5; done_data = 32'h5; step(); idle();
        checks++; if (result_valid !== 1'b0 || count !== 3'd0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL kill_late_done got %b/%0d/%b want 0/0/1", result_valid, count, alloc_ready); end
    endtask

    task automatic test_simul_alloc_retire();
        alloc_valid = 1; alloc_id = 1; alloc_rd = 1; alloc_we = 1; commit_valid = 1; commit_id = 1; step(); idle();
        done_valid = 1; done_id = 1; done_data = 32'h55; step(); idle();
        result_ready = 1; alloc_valid = 1; alloc_id = 2; alloc_rd = 4; alloc_we = 1; step(); idle();
        checks++; if (count !== 3'd1 || result_valid !== 1'b0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL simul_count got %0d/%b/%b want 1/0/1", count, result_valid, alloc_ready); end
        commit_valid = 1; commit_id = 2; commit_kill = 1; step(); idle();
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL simul_cleanup got %0d want 0", count); end
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k < 4; k++) begin
            alloc_valid = 1; alloc_id = 4'(k); alloc_rd = 5'(k); alloc_we = 1; commit_valid = 1; commit_id = 4'(k); step(); idle();
        end
        checks++; if (count !== 3'd4 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_state got %0d/%b want 4/0", count, alloc_ready); end
        for (int k = 0; k < 4; k++) begin
            alloc_valid = 1; alloc_id = 4'd15; done_valid = 1; done_id = 4'(k); done_data = 32'hA0000000 + k; step(); idle();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_no_overflow got %0d want 4", count); end
        for (int r = 0; r < 10; r++) begin
            checks++; if (result_valid !== 1'b1 || result_id !== 4'(r) || result_data !== 32'hA0000000 + r) begin
                errors++; $display("FAIL wrap_head%0d got %b/%0d/%h want 1/%0d/%h", r, result_valid, result_id, result_data, r, 32'hA0000000 + r);
            end
            result_ready = 1; alloc_valid = 1; alloc_id = 4'(r + 4); alloc_rd = 5'(r + 4); alloc_we = 1; step(); idle();
            checks++; if (count !== 3'd3 || alloc_ready !== 1'b1) begin errors++; $display("FAIL wrap_retire%0d got %0d/%b want 3/1", r, count, alloc_ready); end
            alloc_valid = 1; alloc_id = 4'(r + 4); alloc_rd = 5'(r + 4); alloc_we = 1; commit_valid = 1; commit_id = 4'(r + 4); step(); idle();
            checks++; if (count !== 3'd4 || alloc_ready !== 1'b0) begin errors++; $display("FAIL wrap_refill%0d got %0d/%b want 4/0", r, count, alloc_ready); end
            done_valid = 1; done_id = 4'(r + 4); done_data = 32'hA0000000 + r + 4; step(); idle();
        end
        for (int j = 0; j < 4; j++) begin
            checks++; if (result_valid !== 1'b1 || result_id !== 4'(10 + j) || result_rd !== 5'(10 + j)) begin
                errors++; $display("FAIL wrap_drain%0d got %b/%0d/%0d want 1/%0d/%0d", j, result_valid, result_id, result_rd, 10 + j, 10 + j);
            end
            result_ready = 1; step(); idle();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_empty got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        alloc_valid = 1; alloc_id = 1; alloc_rd = 1; alloc_we = 1; step(); idle();
        alloc_valid = 1; alloc_id = 2; alloc_rd = 2; alloc_we = 1; done_valid = 1; done_id = 1; done_data = 32'h77; step(); idle();
        commit_valid = 1; commit_id = 1; step(); idle();
        checks++; if (count !== 3'd2 || result_valid !== 1'b1) begin errors++; $display("FAIL mid_before got %0d/%b want 2/1", count, result_valid); end
        rst = 1; alloc_valid = 1; alloc_id = 7; commit_valid = 1; commit_id = 2; result_ready = 1; step(); idle();
        checks++; if (count !== 3'd0 || result_valid !== 1'b0 || alloc_ready !== 1'b0 || result_id !== 4'd0) begin errors++; $display("FAIL mid_reset got %0d/%b/%b/%0d want 0/0/0/0", count, result_valid, alloc_ready, result_id); end
        rst = 0; #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", alloc_ready); end
        alloc_valid = 1; alloc_id = 4; alloc_rd = 4; alloc_we = 1; commit_valid = 1; commit_id = 4; step(); idle();
        done_valid = 1; done_id = 4; done_data = 32'h44; step(); idle();
        checks++; if (result_valid !== 1'b1 || result_id !== 4'd4 || result_data !== 32'h44) begin errors++; $display("FAIL mid_after got %b/%0d/%h want 1/4/44", result_valid, result_id, result_data); end
        result_ready = 1; step(); idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_drain got %0d want 0", count); end
    endtask

`ifdef XIF_TRACKER_FLUSH_EN
    task automatic test_flush();
        alloc_valid = 1; alloc_id = 1; alloc_rd = 1; alloc_we = 1; step(); idle();
        alloc_valid = 1; alloc_id = 2; alloc_rd = 2; alloc_we = 1; step(); idle();
        commit_valid = 1; commit_id = 1; step(); idle();
        flush = 1; step(); idle();
        checks++; if (count !== 3'd2 || result_valid !== 1'b0) begin errors++; $display("FAIL flush_marked got %0d/%b want 2/0", count, result_valid); end
        done_valid = 1; done_id = 1; done_data = 32'h11; step(); idle();
        checks++; if (result_valid !== 1'b1 || result_id !== 4'd1) begin errors++; $display("FAIL flush_survivor got %b/%0d want 1/1", result_valid, result_id); end
        result_ready = 1; step(); idle();
        checks++; if (result_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL flush_killed_head got %b/%0d want 0/1", result_valid, count); end
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_drain got %0d want 0", count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_in_order();
        test_hold();
        test_kill();
        test_simul_alloc_retire();
        test_full_wrap();
        test_reset_mid();
`ifdef XIF_TRACKER_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xif_result_tracker.md
XIF_RESULT_TRACKER -- requirements
Module: xif_result_tracker

Interface
REQ-001 Parameter DEPTH, default 4, number of tracked in-flight instructions; power of two, >= 2.
REQ-002 Parameter X_ID_WIDTH, default 4, width of the XIF instruction id.
REQ-003 Parameter FLEN, default 32, result data width.
REQ-004 ck  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 alloc_valid  input  1  accepted issue requests an entry.
REQ-007 alloc_ready  output  1  entry available.
REQ-008 alloc_id / alloc_rd / alloc_we  input  X_ID_WIDTH / 5 / 1  id, destination register, writeback flag of the new entry.
REQ-009 commit_valid / commit_id / commit_kill  input  1 / X_ID_WIDTH / 1  XIF commit transaction.
REQ-010 done_valid / done_id / done_data  input  1 / X_ID_WIDTH / FLEN  execution completion and result.
REQ-011 result_valid  output  1  result presented.
REQ-012 result_ready  input  1  core accepts result.
REQ-013 result_id / result_rd / result_we / result_data  output  X_ID_WIDTH / 5 / 1 / FLEN  result fields of the head entry.
REQ-014 count  output  clog2(DEPTH)+1  live entries, killed-but-unretired included.

Function
REQ-015 Circular buffer of DEPTH entries (head, tail, count); entry fields: valid, id, rd, we, committed, killed, done, data.
REQ-016 alloc_ready SHALL equal (count < DEPTH) && !rst, independent of alloc_valid; no same-cycle bypass when full, even if head retires.
REQ-017 alloc_valid && alloc_ready SHALL write the tail entry (committed=killed=done=0) and advance tail modulo DEPTH.
REQ-018 commit_valid SHALL match the oldest valid entry with id == commit_id, including the entry allocated in the same cycle; set committed, plus killed if commit_kill; no match -> ignored, no state change.
REQ-019 done_valid SHALL match the oldest valid, non-done entry with id == done_id; set done and capture done_data; no match -> ignored.
REQ-020 Commit and done to the same entry in one cycle SHALL both apply.
REQ-021 result_valid SHALL be 1 iff head entry valid && committed && done && !killed; result fields driven from head entry registers, all zero when result_valid is 0.
REQ-022 Latency: last of commit/done in cycle N -> result_valid in cycle N+1 when entry is at head.
REQ-023 result_valid && result_ready SHALL retire head (valid=0, head+1 modulo DEPTH, count-1).
REQ-024 Fields SHALL hold stable while result_valid && !result_ready.
REQ-025 Killed head entry SHALL retire silently in one cycle regardless of done; at most one retire per cycle; a late done for it is ignored.
REQ-026 Simultaneous alloc and retire SHALL leave count unchanged; head and tail wrap independently.
REQ-027 Entries with alloc_we=0 SHALL still produce a result with result_we=0.

Reset
REQ-028 While rst is high at a rising edge: all entries invalid, head=tail=0, count=0; rst overrides any concurrent alloc/commit/done/retire.
REQ-029 Reset values: result_valid=0, result_id=0, result_rd=0, result_we=0, result_data=0, count=0, alloc_ready=0 during rst and 1 the cycle after.

Configuration
REQ-030 Macro XIF_TRACKER_FLUSH_EN defined: extra input flush (1 bit); flush high at a rising edge SHALL mark every valid non-committed entry killed; a same-cycle commit without kill takes priority for its entry; a same-cycle alloc is also killed.
REQ-031 XIF_TRACKER_FLUSH_EN undefined: no flush port; entries killed only via commit_kill.

Verification
REQ-032 Alloc id 3, commit id 3 kill=0, done id 3 data 0x3F800000 -> next cycle result_valid=1, result_id=3, result_data=0x3F800000; result_ready=1 -> count 0.
REQ-033 Alloc ids 1,2; done 2 then done 1; commit both -> result id 1 first, then id 2 (in order).
REQ-034 Alloc 4 entries (DEPTH=4) -> alloc_ready=0, count=4; retire one with alloc_valid held -> no alloc that cycle, alloc_ready=1 next cycle; repeat 10 times -> wrap-around correct.
REQ-035 Alloc id 5, commit id 5 kill=1, no done -> entry retires silently next cycle, result_valid never 1, count 0.
REQ-036 result_valid=1 with result_ready=0 for 3 cycles -> fields constant; rst pulse mid-operation with 2 live entries -> count=0, result_valid=0 next cycle.
REQ-037 With XIF_TRACKER_FLUSH_EN: alloc ids 1,2, commit id 1, flush -> id 1 result produced, id 2 retired silently.
